memory_arbiter: RTL and testbench
=================================

# memory_arbiter

Arbitrates the single-port unified RAM between the pipeline's instruction fetch and data load/store requests. Returns registered data and one-cycle `ihit`/`dhit` pulses to the datapath; these pulses are what the hazard unit consumes to generate stage enables and flushes. Sits between the datapath request logic and the RAM model/controller.

## Interface
- `WORD_W`, 32: address and data width.
- `CLK`  in  1  system clock, rising edge.
- `RST`  in  1  asynchronous, active-high reset.
- `iREN`  in  1  instruction read request, held until `ihit`.
- `iaddr`  in  WORD_W  fetch address.
- `iload`  out  WORD_W  fetched instruction (registered).
- `ihit`  out  1  one-cycle fetch completion pulse.
- `dREN`, `dWEN`  in  1 each  data read / write request, held until `dhit`.
- `daddr`, `dstore`  in  WORD_W  data address, store data.
- `dload`  out  WORD_W  loaded word (registered).
- `dhit`  out  1  one-cycle data completion pulse.
- `ramREN`, `ramWEN`  out  1 each  RAM strobes.
- `ramaddr`, `ramstore`  out  WORD_W  RAM address, write data.
- `ramload`  in  WORD_W  RAM read data, valid when `ramstate == ACCESS`.
- `ramstate`  in  ramstate_t  FREE/BUSY/ACCESS/ERROR.

## Operation
- FSM states: IDLE, IACC, DACC, IRESP, DRESP.
- IDLE: if `dREN|dWEN` -> latch daddr/dstore/write flag, go DACC; else if `iREN` -> latch iaddr, go IACC. Data has priority.
- `dREN & dWEN` together: treated as write.
- IACC/DACC: drive `ramREN` (or `ramWEN`), `ramaddr`, `ramstore` from latched registers only; inputs may change without effect.
- `ramstate == ACCESS`: capture `ramload` into `iload`/`dload` (writes leave `dload` unchanged), go IRESP/DRESP. BUSY/FREE: hold. ERROR: stay, re-issue same access next cycle (retry indefinitely).
- In-flight access is never aborted; a data request arriving during IACC waits for it to finish.
- IRESP/DRESP: pulse hit only if the requester still asserts REN (any write/read for data side) with address equal to latched address; otherwise the result is discarded silently (PC redirect/flush). Always return to IDLE next cycle.
- RAM strobes are 0 in IDLE, IRESP, DRESP.

## Timing
- Reset: state IDLE; `ihit`, `dhit`, `ramREN`, `ramWEN` = 0; `iload`, `dload`, `ramaddr`, `ramstore` = 0.
- Request sampled in IDLE at edge k; RAM strobes asserted cycle k+1. If ACCESS arrives in cycle k+1+L, hit is high during cycle k+2+L. Zero-wait RAM: hit 2 cycles after request visible.
- Hit lasts exactly one cycle; at least one IDLE cycle between consecutive accesses (a request still asserted in the hit cycle is not re-served).
- Back-to-back fetches with zero-wait RAM: one `ihit` every 3 cycles.
- `RST` mid-access: immediate return to reset values; the pending access is lost, no hit.

## Configuration
- `MEMORY_ARBITER_IBUF_EN` defined: one-entry instruction buffer (valid, tag, word). In IDLE with only `iREN` and `iaddr == tag & valid`, go straight to IRESP with buffered word, no RAM access (hit 1 cycle after request). Buffer filled on every completed fetch; invalidated by any data write whose address equals tag, and by reset.
- Undefined: every fetch goes to RAM; no buffer state exists.

## Structure
- `ramstate_t`, `word_t` already come from `cpu_types_pkg`; add `arb_state_t` (5-state enum) there.
- Sub-module `iload_buf` (buffer storage, tag compare, invalidate) instantiated only under `MEMORY_ARBITER_IBUF_EN`.

## Test plan
- Reset: assert `RST` with requests pending -> all outputs 0, no strobes until released.
- Zero-wait fetch: `iREN=1`, `iaddr=0x0000_0040`, RAM returns ACCESS at once with `0x2008_0001` -> `ihit` one cycle, 2 cycles after request, `iload=0x2008_0001`.
- Priority: `iREN` and `dREN` (`daddr=0x100`) together in IDLE -> data served first, `dhit`, then fetch served, `ihit`; never both high.
- Wait states/error: RAM BUSY 3 cycles, ERROR 1, then ACCESS for store `0x100 <- 0xDEAD_BEEF` -> `ramWEN` held throughout, `dhit` once, `dload` unchanged.
- Redirect: change `iaddr` from 0x40 to 0x80 during IACC -> no `ihit` for 0x40; 0x80 fetched next, `ihit` with its data.
- With `MEMORY_ARBITER_IBUF_EN`: fetch 0x40 twice -> second `ihit` 1 cycle after request, no `ramREN`; store to 0x40 then fetch -> RAM read occurs.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: word/RAM status types plus the memory arbiter state encoding.
package cpu_types_pkg;
  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;

  typedef enum logic [2:0] {IDLE, IACC, DACC, IRESP, DRESP} arb_state_t;
endpackage

// File: rtl/memory_arbiter_if.sv
// Datapath request/response and RAM strobe signals seen by the memory arbiter.
interface memory_arbiter_if;
  import cpu_types_pkg::*;

  logic      iREN;
  word_t     iaddr;
  word_t     iload;
  logic      ihit;
  logic      dREN;
  logic      dWEN;
  word_t     daddr;
  word_t     dstore;
  word_t     dload;
  logic      dhit;
  logic      ramREN;
  logic      ramWEN;
  word_t     ramaddr;
  word_t     ramstore;
  word_t     ramload;
  ramstate_t ramstate;

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore,
    input  iload, ihit, dload, dhit
  );

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iload, ihit, dload, dhit, ramREN, ramWEN, ramaddr, ramstore
  );

  modport ram (
    input  ramREN, ramWEN, ramaddr, ramstore,
    output ramload, ramstate
  );
endinterface

// File: rtl/memory_arbiter_iload_buf.sv
// One-entry fetch buffer (valid, tag, word); used only with MEMORY_ARBITER_IBUF_EN.
module iload_buf
  import cpu_types_pkg::*;
(
  input  logic  CLK,
  input  logic  RST,
  input  logic  fill_en,
  input  word_t fill_addr,
  input  word_t fill_word,
  input  logic  inval_en,
  input  word_t inval_addr,
  input  word_t lookup_addr,
  output logic  hit,
  output word_t word
);
  logic  valid_q, valid_d;
  word_t tag_q, tag_d;
  word_t word_q, word_d;

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    word_d  = word_q;
    if (fill_en) begin
      valid_d = 1'b1;
      tag_d   = fill_addr;
      word_d  = fill_word;
    end else if (inval_en && inval_addr == tag_q) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      word_q  <= '0;
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      word_q  <= word_d;
    end
  end

  assign hit  = valid_q && (lookup_addr == tag_q);
  assign word = word_q;
endmodule

// File: rtl/memory_arbiter.sv
// Single-port RAM arbiter between instruction fetch and data access, data first.
// Optional one-entry fetch buffer enabled by defining MEMORY_ARBITER_IBUF_EN.
module memory_arbiter
  import cpu_types_pkg::*;
(
  input  logic CLK,
  input  logic RST,
  memory_arbiter_if.slave bus
);
  arb_state_t state_q, state_d;
  word_t      addr_q, addr_d;
  word_t      store_q, store_d;
  word_t      iload_q, iload_d;
  word_t      dload_q, dload_d;
  logic       wr_q, wr_d;

  logic  d_req;
  logic  ram_done;
  logic  buf_hit;
  word_t buf_word;

  assign d_req    = bus.dREN | bus.dWEN;
  assign ram_done = (bus.ramstate == ACCESS);

`ifdef MEMORY_ARBITER_IBUF_EN
  iload_buf u_iload_buf (
    .CLK         (CLK),
    .RST         (RST),
    .fill_en     (state_q == IACC && ram_done),
    .fill_addr   (addr_q),
    .fill_word   (bus.ramload),
    .inval_en    (state_q == DACC && wr_q && ram_done),
    .inval_addr  (addr_q),
    .lookup_addr (bus.iaddr),
    .hit         (buf_hit),
    .word        (buf_word)
  );
`else
  assign buf_hit  = 1'b0;
  assign buf_word = '0;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    store_d = store_q;
    wr_d    = wr_q;
    iload_d = iload_q;
    dload_d = dload_q;
    case (state_q)
      IDLE: begin
        if (d_req) begin
          state_d = DACC;
          addr_d  = bus.daddr;
          store_d = bus.dstore;
          wr_d    = bus.dWEN;
        end else if (bus.iREN) begin
          addr_d = bus.iaddr;
          if (buf_hit) begin
            state_d = IRESP;
            iload_d = buf_word;
          end else begin
            state_d = IACC;
          end
        end
      end
      // ERROR and BUSY both hold here with strobes still asserted, so the RAM retries.
      IACC: begin
        if (ram_done) begin
          state_d = IRESP;
          iload_d = bus.ramload;
        end
      end
      DACC: begin
        if (ram_done) begin
          state_d = DRESP;
          if (!wr_q) dload_d = bus.ramload;
        end
      end
      IRESP, DRESP: state_d = IDLE;
      default:      state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      addr_q  <= '0;
      store_q <= '0;
      iload_q <= '0;
      dload_q <= '0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      store_q <= store_d;
      iload_q <= iload_d;
      dload_q <= dload_d;
      wr_q    <= wr_d;
    end
  end

  // A result is only reported if the requester still wants the same address.
  assign bus.ihit     = (state_q == IRESP) && bus.iREN && (bus.iaddr == addr_q);
  assign bus.dhit     = (state_q == DRESP) && d_req && (bus.daddr == addr_q);
  assign bus.ramREN   = (state_q == IACC) || (state_q == DACC && !wr_q);
  assign bus.ramWEN   = (state_q == DACC) && wr_q;
  assign bus.ramaddr  = addr_q;
  assign bus.ramstore = store_q;
  assign bus.iload    = iload_q;
  assign bus.dload    = dload_q;
endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: directed scenarios plus random traffic
// against a transaction-level model with a wait-state RAM.
module tb_memory_arbiter;
  import cpu_types_pkg::*;

`ifdef MEMORY_ARBITER_IBUF_EN
  localparam bit IBUF = 1'b1;
`else
  localparam bit IBUF = 1'b0;
`endif

  logic CLK = 1'b0;
  logic RST;
  memory_arbiter_if bus ();

  memory_arbiter dut (.CLK(CLK), .RST(RST), .bus(bus));

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_pass   = 0;

  // RAM model: plan_wait non-ACCESS cycles per access, ERROR on cycle plan_err
  int       plan_wait = 0;
  int       plan_err  = -1;
  int       strobe_cycles = 0;
  word_t    ram_mem [256];
  bit [255:0] ram_wr;

  function automatic word_t init_word(word_t a);
    return (a == 32'h40) ? 32'h2008_0001 : ((a * 32'h9E37_79B1) ^ 32'hA5A5_0000);
  endfunction

  always @(posedge CLK) begin
    if (bus.ramREN || bus.ramWEN) strobe_cycles <= strobe_cycles + 1;
    else                          strobe_cycles <= 0;
    if (bus.ramWEN && bus.ramstate == ACCESS) begin
      ram_mem[bus.ramaddr[9:2]] <= bus.ramstore;
      ram_wr[bus.ramaddr[9:2]]  <= 1'b1;
    end
  end

  always_comb begin
    bus.ramload = ram_wr[bus.ramaddr[9:2]] ? ram_mem[bus.ramaddr[9:2]] : init_word(bus.ramaddr);
    if (!(bus.ramREN || bus.ramWEN))  bus.ramstate = FREE;
    else if (strobe_cycles < plan_wait) bus.ramstate = (strobe_cycles == plan_err) ? ERROR : BUSY;
    else                              bus.ramstate = ACCESS;
  end

  // Reference model: architectural memory, expected dload, fetch buffer contents
  word_t    ref_mem [256];
  bit [255:0] ref_wr;
  word_t    exp_dload = '0;
  bit       buf_valid = 1'b0;
  word_t    buf_tag   = '0;

  function automatic word_t ref_read(word_t a);
    return ref_wr[a[9:2]] ? ref_mem[a[9:2]] : init_word(a);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // kind: 0 fetch, 1 load, 2 store (both=1 also raises dREN)
  task automatic run_txn(input int kind, input word_t a, input word_t wdata,
                         input int wt, input int er, input bit both);
    bit bufhit;
    int exp_lat;
    int lat;
    bufhit  = IBUF && (kind == 0) && buf_valid && (buf_tag == a);
    exp_lat = bufhit ? 1 : 2 + wt;
    plan_wait = wt;
    plan_err  = er;
    lat = 0;
    @(negedge CLK);
    if (kind == 0) begin
      bus.iREN = 1'b1; bus.iaddr = a;
    end else begin
      bus.daddr = a; bus.dstore = wdata;
      bus.dREN = (kind == 1) || both;
      bus.dWEN = (kind == 2);
    end
    for (int c = 1; c <= 40 && lat == 0; c++) begin
      @(negedge CLK);
      chk("not_both_hits", 32'(bus.ihit & bus.dhit), 32'd0);
      if (bufhit && c == 1) begin
        chk("ibuf_no_ram", 32'({bus.ramREN, bus.ramWEN}), 32'd0);
      end else if (!bufhit && c <= 1 + wt) begin
        chk("ramREN", 32'(bus.ramREN), 32'(kind != 2));
        chk("ramWEN", 32'(bus.ramWEN), 32'(kind == 2));
        chk("ramaddr", bus.ramaddr, a);
        if (kind == 2) chk("ramstore", bus.ramstore, wdata);
      end
      if ((kind == 0) ? bus.ihit : bus.dhit) lat = c;
      if (!bufhit && wt >= 1 && c == 1) begin
        bus.iaddr = a ^ 32'h1000; bus.daddr = a ^ 32'h1000; bus.dstore = ~wdata;
      end
      if (!bufhit && wt >= 1 && c == 1 + wt) begin
        bus.iaddr = a; bus.daddr = a; bus.dstore = wdata;
      end
    end
    chk("hit_latency", lat, exp_lat);
    if (kind == 0) begin
      chk("iload", bus.iload, ref_read(a));
      buf_valid = 1'b1; buf_tag = a;
    end else if (kind == 1) begin
      exp_dload = ref_read(a);
      chk("dload_read", bus.dload, exp_dload);
    end else begin
      chk("dload_after_write", bus.dload, exp_dload);
      ref_mem[a[9:2]] = wdata; ref_wr[a[9:2]] = 1'b1;
      if (buf_tag == a) buf_valid = 1'b0;
    end
    bus.iREN = 1'b0; bus.dREN = 1'b0; bus.dWEN = 1'b0;
    @(negedge CLK);
    chk("gap_no_hit", 32'({bus.ihit, bus.dhit}), 32'd0);
    chk("gap_no_strobe", 32'({bus.ramREN, bus.ramWEN}), 32'd0);
  endtask

  initial begin
    int il;
    int dl;
    bit bufhit;
    // reset with requests pending
    RST = 1'b1;
    bus.iREN = 1'b1; bus.iaddr = 32'h40;
    bus.dREN = 1'b1; bus.dWEN = 1'b0; bus.daddr = 32'h100; bus.dstore = 32'h1234_5678;
    repeat (3) @(negedge CLK);
    chk("rst_ihit", 32'(bus.ihit), 32'd0);
    chk("rst_dhit", 32'(bus.dhit), 32'd0);
    chk("rst_ramREN", 32'(bus.ramREN), 32'd0);
    chk("rst_ramWEN", 32'(bus.ramWEN), 32'd0);
    chk("rst_iload", bus.iload, 32'd0);
    chk("rst_dload", bus.dload, 32'd0);
    chk("rst_ramaddr", bus.ramaddr, 32'd0);
    chk("rst_ramstore", bus.ramstore, 32'd0);
    bus.iREN = 1'b0; bus.dREN = 1'b0;
    RST = 1'b0;

    // zero-wait fetch
    run_txn(0, 32'h40, '0, 0, -1, 1'b0);
    chk("fetch40_word", bus.iload, 32'h2008_0001);

    // simultaneous data and fetch requests: data served first
    plan_wait = 0; plan_err = -1;
    bufhit = IBUF && buf_valid && (buf_tag == 32'h40);
    @(negedge CLK);
    bus.iREN = 1'b1; bus.iaddr = 32'h40; bus.dREN = 1'b1; bus.daddr = 32'h100;
    dl = 0; il = 0;
    for (int c = 1; c <= 40 && il == 0; c++) begin
      @(negedge CLK);
      chk("prio_not_both", 32'(bus.ihit & bus.dhit), 32'd0);
      if (bus.dhit && dl == 0) begin
        dl = c;
        chk("prio_dload", bus.dload, ref_read(32'h100));
        bus.dREN = 1'b0;
      end
      if (bus.ihit) begin
        il = c;
        bus.iREN = 1'b0;
      end
    end
    chk("prio_dlat", dl, 2);
    chk("prio_ilat", il, bufhit ? 4 : 5);
    chk("prio_iload", bus.iload, ref_read(32'h40));
    exp_dload = ref_read(32'h100);
    buf_valid = 1'b1; buf_tag = 32'h40;
    @(negedge CLK);

    // store through BUSY x3, ERROR x1, then ACCESS; read it back
    run_txn(2, 32'h100, 32'hDEAD_BEEF, 4, 3, 1'b0);
    run_txn(1, 32'h100, '0, 1, -1, 1'b0);
    chk("readback_beef", bus.dload, 32'hDEAD_BEEF);

    // store to the buffered fetch address, then fetch redirected 0x40 -> 0x80
    run_txn(2, 32'h40, 32'h0BAD_F00D, 0, -1, 1'b0);
    plan_wait = 2; plan_err = -1;
    @(negedge CLK);
    bus.iREN = 1'b1; bus.iaddr = 32'h40;
    il = 0;
    for (int c = 1; c <= 40 && il == 0; c++) begin
      @(negedge CLK);
      if (c == 1) begin
        chk("redir_ram_read", 32'(bus.ramREN), 32'd1);
        bus.iaddr = 32'h80;
      end
      if (bus.ihit) il = c;
    end
    chk("redir_lat", il, 9);
    chk("redir_iload", bus.iload, ref_read(32'h80));
    bus.iREN = 1'b0;
    buf_valid = 1'b1; buf_tag = 32'h80;
    @(negedge CLK);

    // repeat fetch (buffer hit when enabled), and read+write together treated as write
    run_txn(0, 32'h80, '0, 0, -1, 1'b0);
    run_txn(2, 32'h48, 32'h5555_AAAA, 1, 0, 1'b1);
    run_txn(1, 32'h48, '0, 0, -1, 1'b0);

    // randomized traffic
    for (int n = 0; n < 40; n++) begin
      int kind;
      int wt;
      int er;
      word_t a;
      kind = int'($urandom_range(0, 2));
      a    = 32'h40 + 32'(4 * $urandom_range(0, 7));
      wt   = int'($urandom_range(0, 3));
      er   = (wt > 0 && $urandom_range(0, 1) == 1) ? int'($urandom_range(0, wt - 1)) : -1;
      run_txn(kind, a, $urandom, wt, er, (kind == 2) && ($urandom_range(0, 1) == 1));
    end

    // reset in the middle of an access: no hit, everything back to zero
    plan_wait = 3; plan_err = -1;
    @(negedge CLK);
    bus.iREN = 1'b1; bus.iaddr = 32'h44;
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    #1;
    chk("midrst_ramREN", 32'(bus.ramREN), 32'd0);
    chk("midrst_iload", bus.iload, 32'd0);
    chk("midrst_ramaddr", bus.ramaddr, 32'd0);
    chk("midrst_dload", bus.dload, 32'd0);
    repeat (2) @(negedge CLK);
    chk("midrst_ihit", 32'(bus.ihit), 32'd0);
    bus.iREN = 1'b0;
    RST = 1'b0;
    exp_dload = '0;
    buf_valid = 1'b0;
    run_txn(0, 32'h80, '0, 0, -1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
